multicycle_control: RTL and testbench

//  Multicycle control FSM for the 16-bit lab CPU. Drives the instruction register's load enable.

---
 rtl/multicycle_control.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the 16-bit lab CPU: fetch/decode/execute sequencing,
// datapath strobes, illegal-opcode pulse and a sticky memory-timeout bus error.
//
// state   | meaning
// FETCH   | read mem[PC]; load IR and bump PC when mem_ready
// DECODE  | classify the IR opcode, pulse illegal for A-E
// EXEC    | ALU op, branch/jump resolution, LW/SW address setup
// MEM     | LW read / SW write at reg[rs], held until mem_ready
// WB      | one-cycle register-file write
// HALT    | parked until reset (HALT opcode or bus timeout)
module multicycle_control #(
    parameter int INSTR_W = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_ready,
    input  logic               zero,
    output logic               ir_en,
    output logic               pc_en,
    output logic [1:0]         pc_src,
    output logic               mem_read,
    output logic               mem_write,
    output logic               addr_sel,
    output logic               reg_write,
    output logic [1:0]         wb_sel,
    output logic [1:0]         alu_op,
    output logic               halted,
    output logic               illegal,
    output logic               bus_error,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LI   = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     st;
    logic [3:0] op_q;
    logic [7:0] wait_cnt;
    logic       bus_err_q;
    logic [3:0] op_d;
    logic       waiting;
    logic       timeout_hit;

    // Operand fields are consumed by the datapath, not by the controller.
    logic unused_fields;
    assign unused_fields = ^instr[INSTR_W-5:0];

    assign op_d        = instr[INSTR_W-1 -: 4];
    assign waiting     = (st == S_FETCH || st == S_MEM) && !mem_ready;
    assign timeout_hit = waiting && (wait_cnt == TMO_LAST);

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h4);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'hA) && (op <= 4'hE);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= S_FETCH;
            op_q      <= OP_NOP;
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            wait_cnt <= (waiting && !timeout_hit) ? wait_cnt + 8'd1 : 8'd0;
            if (timeout_hit)
                bus_err_q <= 1'b1;
            case (st)
                S_FETCH: begin
                    if (mem_ready)
                        st <= S_DECODE;
                    else if (timeout_hit)
                        st <= S_HALT;
                end
                S_DECODE: begin
                    // Latch the opcode so later IR changes cannot disturb this instruction.
                    op_q <= op_d;
                    if (op_d == OP_NOP || is_illegal(op_d))
                        st <= S_FETCH;
                    else if (op_d == OP_LI)
                        st <= S_WB;
                    else if (op_d == OP_HALT)
                        st <= S_HALT;
                    else
                        st <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_alu(op_q))
                        st <= S_WB;
                    else if (op_q == OP_LW || op_q == OP_SW)
                        st <= S_MEM;
                    else
                        st <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_ready)
                        st <= (op_q == OP_LW) ? S_WB : S_FETCH;
                    else if (timeout_hit)
                        st <= S_HALT;
                end
                S_WB:    st <= S_FETCH;
                S_HALT:  st <= S_HALT;
                default: st <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        pc_src    = 2'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr_sel  = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        alu_op    = 2'd0;
        halted    = 1'b0;
        illegal   = 1'b0;
        bus_error = 1'b0;
        state     = 3'd0;
        if (!reset) begin
            bus_error = bus_err_q;
            state     = st;
            case (st)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_en    = mem_ready;
                    pc_en    = mem_ready;
                end
                S_DECODE: illegal = is_illegal(op_d);
                S_EXEC: begin
                    if (is_alu(op_q))
                        alu_op = 2'(op_q - 4'h1);
                    if (op_q == OP_BEQZ) begin
                        pc_en  = zero;
                        pc_src = 2'd1;
                    end else if (op_q == OP_JMP) begin
                        pc_en  = 1'b1;
                        pc_src = 2'd2;
                    end
                end
                S_MEM: begin
                    addr_sel  = 1'b1;
                    mem_read  = (op_q == OP_LW);
                    mem_write = (op_q == OP_SW);
                end
                S_WB: begin
                    reg_write = 1'b1;
                    if (is_alu(op_q))
                        alu_op = 2'(op_q - 4'h1);
                    if (op_q == OP_LW)
                        wb_sel = 2'd1;
                    else if (op_q == OP_LI)
                        wb_sel = 2'd2;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control: per-cycle table of inputs and
// expected outputs, plus a hand-written bus-timeout sequence.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        mem_ready;
    logic        zero;
    logic        ir_en, pc_en, mem_read, mem_write, addr_sel, reg_write;
    logic        halted, illegal, bus_error;
    logic [1:0]  pc_src, wb_sel, alu_op;
    logic [2:0]  state;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .zero(zero),
        .ir_en(ir_en), .pc_en(pc_en), .pc_src(pc_src), .mem_read(mem_read),
        .mem_write(mem_write), .addr_sel(addr_sel), .reg_write(reg_write),
        .wb_sel(wb_sel), .alu_op(alu_op), .halted(halted), .illegal(illegal),
        .bus_error(bus_error), .state(state)
    );

    // {state, ir_en, pc_en, pc_src, mem_read, mem_write, addr_sel, reg_write, wb_sel, alu_op, halted, illegal, bus_error}
    typedef struct {
        string       tag;
        logic        rst;
        logic [15:0] ins;
        logic        rdy;
        logic        z;
        logic [17:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [17:0] outs();
        return {state, ir_en, pc_en, pc_src, mem_read, mem_write, addr_sel, reg_write,
                wb_sel, alu_op, halted, illegal, bus_error};
    endfunction

    task automatic chk(input string name, input logic [17:0] got, input logic [17:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", name, got, exp);
        end
    endtask

    task automatic v(input string tag, input logic rst, input logic [15:0] ins,
                     input logic rdy, input logic z, input logic [2:0] st,
                     input logic ir, input logic pc, input logic [1:0] src,
                     input logic mrd, input logic mwr, input logic as, input logic rw,
                     input logic [1:0] wb, input logic [1:0] alu,
                     input logic hlt, input logic ill, input logic be);
        vec_t e;
        e.tag = tag; e.rst = rst; e.ins = ins; e.rdy = rdy; e.z = z;
        e.exp = {st, ir, pc, src, mrd, mwr, as, rw, wb, alu, hlt, ill, be};
        vq.push_back(e);
    endtask

    // FETCH with memory ready, then DECODE of a legal opcode
    task automatic fe(input string tag, input logic [15:0] ins);
        v({tag, "_fe"}, 0, ins, 1, 0, 3'd0, 1, 1, 2'd0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0);
    endtask
    task automatic de(input string tag, input logic [15:0] ins);
        v({tag, "_de"}, 0, ins, 1, 0, 3'd1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build();
        v("rst0", 1, 16'h1123, 1, 0, 3'd0, 0,0,2'd0, 0,0,0,0, 2'd0,2'd0, 0,0,0);
        v("rst1", 1, 16'h1123, 1, 0, 3'd0, 0,0,2'd0, 0,0,0,0, 2'd0,2'd0, 0,0,0);
        fe("add", 16'h1123); de("add", 16'h1123);
        v("add_ex", 0, 16'h1123, 1, 0, 3'd2, 0,0,2'd0, 0,0,0,0, 2'd0,2'd0, 0,0,0);
        v("add_wb", 0, 16'h1123, 1, 0, 3'd4, 0,0,2'd0, 0,0,0,1, 2'd0,2'd0, 0,0,0);
        v("fe_wait", 0, 16'h2123, 0, 0, 3'd0, 0,0,2'd0, 1,0,0,0, 2'd0,2'd0, 0,0,0);
        // IR changed to SW after DECODE: must still finish as SUB
        fe("sub", 16'h2123); de("sub", 16'h2123);
        v("sub_ex", 0, 16'h7000, 1, 0, 3'd2, 0,0,2'd0, 0,0,0,0, 2'd0,2'd1, 0,0,0);
        v("sub_wb", 0, 16'h7000, 1, 0, 3'd4, 0,0,2'd0, 0,0,0,1, 2'd0,2'd1, 0,0,0);
        fe("and", 16'h3123); de("and", 16'h3123);
        v("and_ex", 0, 16'h3123, 1, 0, 3'd2, 0,0,2'd0, 0,0,0,0, 2'd0,2'd2, 0,0,0);
        v("and_wb", 0, 16'h3123, 1, 0, 3'd4, 0,0,2'd0, 0,0,0,1, 2'd0,2'd2, 0,0,0);
        fe("or", 16'h4123); de("or", 16'h4123);
        v("or_ex", 0, 16'h4123, 1, 0, 3'd2, 0,0,2'd0, 0,0,0,0, 2'd0,2'd3, 0,0,0);
        v("or_wb", 0, 16'h4123, 1, 0, 3'd4, 0,0,2'd0, 0,0,0,1, 2'd0,2'd3, 0,0,0);
        fe("li", 16'h5105); de("li", 16'h5105);
        v("li_wb", 0, 16'h5105, 1, 0, 3'd4, 0,0,2'd0, 0,0,0,1, 2'd2,2'd0, 0,0,0);
        fe("lw", 16'h6340); de("lw", 16'h6340);
        v("lw_ex", 0, 16'h6340, 1, 0, 3'd2, 0,0,2'd0, 0,0,0,0, 2'd0,2'd0, 0,0,0);
        for (int i = 0; i < 3; i++)
            v("lw_memwait", 0, 16'h6340, 0, 0, 3'd3, 0,0,2'd0, 1,0,1,0, 2'd0,2'd0, 0,0,0);
        v("lw_mem", 0, 16'h6340, 1, 0, 3'd3, 0,0,2'd0, 1,0,1,0, 2'd0,2'd0, 0,0,0);
        v("lw_wb", 0, 16'h6340, 1, 0, 3'd4, 0,0,2'd0, 0,0,0,1, 2'd1,2'd0, 0,0,0);
        fe("sw", 16'h7340); de("sw", 16'h7340);
        v("sw_ex", 0, 16'h7340, 1, 0, 3'd2, 0,0,2'd0, 0,0,0,0, 2'd0,2'd0, 0,0,0);
        for (int i = 0; i < 2; i++)
            v("sw_memwait", 0, 16'h7340, 0, 0, 3'd3, 0,0,2'd0, 0,1,1,0, 2'd0,2'd0, 0,0,0);
        v("sw_mem", 0, 16'h7340, 1, 0, 3'd3, 0,0,2'd0, 0,1,1,0, 2'd0,2'd0, 0,0,0);
        fe("beqz1", 16'h8205); de("beqz1", 16'h8205);
        v("beqz1_ex", 0, 16'h8205, 1, 1, 3'd2, 0,1,2'd1, 0,0,0,0, 2'd0,2'd0, 0,0,0);
        fe("beqz0", 16'h8205); de("beqz0", 16'h8205);
        v("beqz0_ex", 0, 16'h8205, 1, 0, 3'd2, 0,0,2'd1, 0,0,0,0, 2'd0,2'd0, 0,0,0);
        fe("jmp", 16'h9010); de("jmp", 16'h9010);
        v("jmp_ex", 0, 16'h9010, 1, 0, 3'd2, 0,1,2'd2, 0,0,0,0, 2'd0,2'd0, 0,0,0);
        fe("nop", 16'h0000); de("nop", 16'h0000);
        fe("ill", 16'hB000);
        v("ill_de", 0, 16'hB000, 1, 0, 3'd1, 0,0,2'd0, 0,0,0,0, 2'd0,2'd0, 0,1,0);
        // reset lands in the middle of an SW memory wait
        fe("swr", 16'h7340); de("swr", 16'h7340);
        v("swr_ex", 0, 16'h7340, 1, 0, 3'd2, 0,0,2'd0, 0,0,0,0, 2'd0,2'd0, 0,0,0);
        v("swr_mem", 0, 16'h7340, 0, 0, 3'd3, 0,0,2'd0, 0,1,1,0, 2'd0,2'd0, 0,0,0);
        v("swr_rst", 1, 16'h7340, 0, 0, 3'd0, 0,0,2'd0, 0,0,0,0, 2'd0,2'd0, 0,0,0);
        v("swr_after", 0, 16'h7340, 0, 0, 3'd0, 0,0,2'd0, 1,0,0,0, 2'd0,2'd0, 0,0,0);
        fe("post", 16'h0000); de("post", 16'h0000);
        fe("halt", 16'hF000); de("halt", 16'hF000);
        for (int i = 0; i < 20; i++)
            v("halt_hold", 0, 16'hF000, logic'(i[0]), 0, 3'd5, 0,0,2'd0, 0,0,0,0, 2'd0,2'd0, 1,0,0);
        v("halt_rst", 1, 16'hF000, 1, 0, 3'd0, 0,0,2'd0, 0,0,0,0, 2'd0,2'd0, 0,0,0);
        fe("after_halt", 16'h0000);
    endtask

    initial begin
        int bad_wait;
        reset = 1'b1; instr = 16'h0; mem_ready = 1'b0; zero = 1'b0;
        build();
        #1;
        foreach (vq[i]) begin
            reset = vq[i].rst; instr = vq[i].ins; mem_ready = vq[i].rdy; zero = vq[i].z;
            #4;
            chk($sformatf("%s[%0d]", vq[i].tag, i), outs(), vq[i].exp);
            step();
        end

        // fetch never completes: 255 waiting FETCH cycles, then HALT with bus_error
        reset = 1'b1; mem_ready = 1'b0; instr = 16'h0000;
        step();
        reset = 1'b0;
        bad_wait = 0;
        for (int i = 0; i < 255; i++) begin
            #4;
            if (state !== 3'd0 || bus_error !== 1'b0 || halted !== 1'b0)
                bad_wait++;
            step();
        end
        n_cmp++;
        if (bad_wait != 0) begin
            n_err++;
            $display("FAIL tmo_wait: %0d early-exit cycles, expected 0", bad_wait);
        end
        #4;
        chk("tmo_halt", outs(), {3'd5, 1'b0,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0, 1'b1,1'b0,1'b1});
        step();
        #4;
        chk("tmo_sticky", outs(), {3'd5, 1'b0,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0, 1'b1,1'b0,1'b1});
        reset = 1'b1;
        #1;
        chk("tmo_in_rst", outs(), 18'h0);
        step();
        reset = 1'b0;
        #4;
        chk("tmo_cleared", outs(), {3'd0, 1'b0,1'b0,2'd0, 1'b1,1'b0,1'b0,1'b0, 2'd0,2'd0, 1'b0,1'b0,1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
